// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped UART transmitter (8N1) that responds on the MMIO port of the
// data-memory crossbar. Bytes written to TXDATA are queued in a small FIFO
// and shifted out LSB first on o_tx. Register reads are purely combinational.
//
// Register map (word offsets within the MMIO window):
//   0 TXDATA  : write pushes i_data[7:0] when i_mask[0]=1; reads 0
//   1 STATUS  : [0] full, [1] empty, [2] busy, [3] overflow (sticky, W1C),
//               [15:8] FIFO count
//   2 DIVISOR : [15:0] bit period minus one, byte-maskable
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_sel    access targets this block; other bus inputs ignored when 0
//   i_addr   word offset within the MMIO window
//   i_data   write data
//   i_wren   write strobe
//   i_mask   byte enables for writes
//   o_data   combinational read data (0 when not selected)
//   o_tx     registered serial output, idle high
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_sel,
   input  logic [29:0] i_addr,
   input  logic [31:0] i_data,
   input  logic        i_wren,
   input  logic [3:0]  i_mask,
   output logic [31:0] o_data,
   output logic        o_tx
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     div_q, div_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [15:0]     period_q, period_d;
   logic [15:0]     reload_q, reload_d;
   logic            tx_q, tx_d;

   logic [7:0]      fifo_mem [FIFO_DEPTH];

   logic            sel_wr, wr_txdata, wr_status, wr_div;
   logic            fifo_full, fifo_empty, push, pop, busy;
   logic [7:0]      count_byte;
   logic            unused_bits;

   assign sel_wr     = i_sel & i_wren;
   assign wr_txdata  = sel_wr && (i_addr == 30'd0) && i_mask[0];
   assign wr_status  = sel_wr && (i_addr == 30'd1) && i_mask[0] && i_data[3];
   assign wr_div     = sel_wr && (i_addr == 30'd2);

   // Full is judged on the pre-edge count, so a pop in the same cycle never
   // makes room for a push that arrives while the FIFO is full.
   assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = wr_txdata & ~fifo_full;
   assign pop        = (state_q == IDLE) & ~fifo_empty;
   assign busy       = (state_q != IDLE);

   assign unused_bits = ^{i_data[31:16], i_mask[3:2]};

   // FIFO bookkeeping, sticky overflow and the divisor register. Overflow
   // set is applied after the W1C clear so that a set in the same cycle wins.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      div_d      = div_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
      if (wr_status) begin
         overflow_d = 1'b0;
      end
      if (wr_txdata && fifo_full) begin
         overflow_d = 1'b1;
      end
      if (wr_div) begin
         if (i_mask[0]) div_d[7:0]  = i_data[7:0];
         if (i_mask[1]) div_d[15:8] = i_data[15:8];
      end
   end

   // Transmit FSM. o_tx is registered, so each transition also chooses the
   // line level for the following cycle. The divisor is captured into
   // reload_q at frame start so mid-frame DIVISOR writes only affect the
   // next frame.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      period_d  = period_q;
      reload_d  = reload_q;
      tx_d      = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               shift_d   = fifo_mem[rd_ptr_q];
               reload_d  = div_q;
               period_d  = div_q;
               bit_cnt_d = '0;
               state_d   = START;
               tx_d      = 1'b0;
            end
         end
         START: begin
            if (period_q == 16'd0) begin
               period_d = reload_q;
               state_d  = DATA;
               tx_d     = shift_q[0];
            end else begin
               period_d = period_q - 16'd1;
            end
         end
         DATA: begin
            if (period_q == 16'd0) begin
               period_d = reload_q;
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               period_d = period_q - 16'd1;
            end
         end
         STOP: begin
            if (period_q == 16'd0) begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end else begin
               period_d = period_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // FIFO storage has no reset; only the pointers and count define contents.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= i_data[7:0];
      end
   end

   // State registers; reset aborts any frame in flight and flushes the FIFO.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         div_q      <= DEFAULT_DIV;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         period_q   <= '0;
         reload_q   <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         div_q      <= div_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         period_q   <= period_d;
         reload_q   <= reload_d;
         tx_q       <= tx_d;
      end
   end

   // Combinational read mux so the crossbar sees data in the same cycle.
   always_comb begin
      count_byte        = '0;
      count_byte[PW:0]  = count_q;
      o_data            = '0;
      if (i_sel) begin
         case (i_addr)
            30'd1:   o_data = {16'h0, count_byte, 4'h0, overflow_q, busy, fifo_empty, fifo_full};
            30'd2:   o_data = {16'h0, div_q};
            default: o_data = '0;
         endcase
      end
   end

   assign o_tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Directed bench for mmio_uart_tx: reset values, register masking, frame
// shape and timing at several divisors, FIFO overflow with W1C clear, and
// reset in the middle of a frame.
module tb_mmio_uart_tx;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_sel;
   logic [29:0] i_addr;
   logic [31:0] i_data;
   logic        i_wren;
   logic [3:0]  i_mask;
   logic [31:0] o_data;
   logic        o_tx;

   int          checkCount;
   int          passCount;
   logic [31:0] rd;

   mmio_uart_tx #(
      .FIFO_DEPTH  (16),
      .DEFAULT_DIV (16'd433)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sel   (i_sel),
      .i_addr  (i_addr),
      .i_data  (i_data),
      .i_wren  (i_wren),
      .i_mask  (i_mask),
      .o_data  (o_data),
      .o_tx    (o_tx)
   );

   // 100 MHz-style free-running clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One bus write, launched at the falling edge and taken at the next
   // rising edge; returns just after that rising edge.
   task automatic applyStimulus(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] mask);
      @(negedge i_clk);
      i_sel  = 1'b1;
      i_wren = 1'b1;
      i_addr = addr;
      i_data = data;
      i_mask = mask;
      @(posedge i_clk);
      #1;
      i_sel  = 1'b0;
      i_wren = 1'b0;
      i_addr = '0;
      i_data = '0;
      i_mask = '0;
   endtask

   // Combinational register read, done away from clock edges.
   task automatic readReg(input logic [29:0] addr, output logic [31:0] data);
      i_sel  = 1'b1;
      i_wren = 1'b0;
      i_addr = addr;
      i_mask = '0;
      #1;
      data   = o_data;
      i_sel  = 1'b0;
      i_addr = '0;
   endtask

   // Waits at most maxWait cycles for the start bit, then checks the line
   // on every cycle of the 10-bit frame. Returns one cycle past the stop bit.
   task automatic checkFrame(input logic [7:0] b, input int bitClks, input int maxWait, input string tag);
      logic [9:0] frame;
      int         w;
      frame = {1'b1, b, 1'b0};
      w = 0;
      while (o_tx === 1'b1 && w < maxWait) begin
         @(posedge i_clk);
         #1;
         w++;
      end
      checkOutput({tag, "_start"}, 32'(o_tx), 32'd0);
      if (o_tx === 1'b0) begin
         for (int c = 0; c < 10 * bitClks; c++) begin
            checkOutput(tag, 32'(o_tx), 32'(frame[c / bitClks]));
            @(posedge i_clk);
            #1;
         end
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      i_rst_n    = 1'b1;
      i_sel      = 1'b0;
      i_wren     = 1'b0;
      i_addr     = '0;
      i_data     = '0;
      i_mask     = '0;

      // Reset values.
      #2 i_rst_n = 1'b0;
      #1 checkOutput("rstTx", 32'(o_tx), 32'd1);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      readReg(30'd1, rd);
      checkOutput("rstStatus", rd, 32'h0000_0002);
      readReg(30'd2, rd);
      checkOutput("rstDivisor", rd, 32'd433);
      i_addr = 30'd2;
      #1 checkOutput("noSelRead", o_data, 32'h0);
      i_addr = '0;
      readReg(30'd0, rd);
      checkOutput("txdataRead", rd, 32'h0);
      readReg(30'd5, rd);
      checkOutput("unmappedRead", rd, 32'h0);

      // Byte-masked writes.
      applyStimulus(30'd2, 32'h1234_5678, 4'b0010);
      readReg(30'd2, rd);
      checkOutput("divMask", rd, 32'h0000_56B1);
      applyStimulus(30'd0, 32'h0000_00FF, 4'b1110);
      readReg(30'd1, rd);
      checkOutput("txMaskNoPush", rd, 32'h0000_0002);
      repeat (3) @(posedge i_clk);
      #1 checkOutput("txMaskIdle", 32'(o_tx), 32'd1);

      // Single frame 0xA5 at DIV=3 with exact start latency.
      applyStimulus(30'd2, 32'd3, 4'b0011);
      applyStimulus(30'd0, 32'h0000_00A5, 4'b0001);
      checkOutput("a5PreFall", 32'(o_tx), 32'd1);
      readReg(30'd1, rd);
      checkOutput("a5Queued", rd, 32'h0000_0100);
      @(posedge i_clk);
      #1 checkOutput("a5Fall", 32'(o_tx), 32'd0);
      readReg(30'd1, rd);
      checkOutput("a5Busy", rd, 32'h0000_0006);
      checkFrame(8'hA5, 4, 0, "a5Frame");
      readReg(30'd1, rd);
      checkOutput("a5Done", rd, 32'h0000_0002);

      // Divisor change during a frame only affects the next frame.
      applyStimulus(30'd0, 32'h0000_003C, 4'b0001);
      fork
         begin
            checkFrame(8'h3C, 4, 1, "divOld");
         end
         begin
            applyStimulus(30'd0, 32'h0000_0081, 4'b0001);
            repeat (10) @(posedge i_clk);
            applyStimulus(30'd2, 32'd7, 4'b0011);
         end
      join
      checkOutput("divGap", 32'(o_tx), 32'd1);
      checkFrame(8'h81, 8, 1, "divNew");
      readReg(30'd1, rd);
      checkOutput("divDone", rd, 32'h0000_0002);

      // Overflow: a long first frame stalls the FIFO while 17 more bytes
      // arrive; the 17th extra byte meets a full FIFO and is dropped.
      applyStimulus(30'd2, 32'd20, 4'b0011);
      applyStimulus(30'd0, 32'h0000_0030, 4'b0001);
      fork
         begin
            checkFrame(8'h30, 21, 1, "ovfFrame0");
         end
         begin
            for (int i = 1; i <= 16; i++) begin
               applyStimulus(30'd0, 32'(8'h30 + i), 4'b0001);
            end
            readReg(30'd1, rd);
            checkOutput("ovfFull", rd, 32'h0000_1005);
            applyStimulus(30'd0, 32'h0000_0041, 4'b0001);
            readReg(30'd1, rd);
            checkOutput("ovfSet", rd, 32'h0000_100D);
            applyStimulus(30'd1, 32'h0000_0008, 4'b0001);
            readReg(30'd1, rd);
            checkOutput("ovfClear", rd, 32'h0000_1005);
            applyStimulus(30'd2, 32'd0, 4'b0011);
         end
      join
      for (int i = 1; i <= 16; i++) begin
         checkOutput("ovfGap", 32'(o_tx), 32'd1);
         checkFrame(8'(8'h30 + i), 1, 1, "ovfFrame");
      end
      repeat (5) @(posedge i_clk);
      #1 checkOutput("ovfNoExtra", 32'(o_tx), 32'd1);
      readReg(30'd1, rd);
      checkOutput("ovfDone", rd, 32'h0000_0002);

      // Reset in the middle of a data bit with bytes still queued.
      applyStimulus(30'd2, 32'd3, 4'b0011);
      applyStimulus(30'd0, 32'h0000_0000, 4'b0001);
      applyStimulus(30'd0, 32'h0000_0000, 4'b0001);
      applyStimulus(30'd0, 32'h0000_0000, 4'b0001);
      repeat (9) @(posedge i_clk);
      #1 checkOutput("midDataLow", 32'(o_tx), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1 checkOutput("midRstTx", 32'(o_tx), 32'd1);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      readReg(30'd1, rd);
      checkOutput("midRstStatus", rd, 32'h0000_0002);
      readReg(30'd2, rd);
      checkOutput("midRstDivisor", rd, 32'd433);
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk);
         #1 checkOutput("midRstQuiet", 32'(o_tx), 32'd1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the MMIO port of the CPU data-memory crossbar as a bus responder. It decodes word-addressed register accesses (address already offset-relative to the MMIO window), buffers bytes in a TX FIFO, and serialises them as 8N1 frames on a single output line. Register reads are combinational so the crossbar's combinational read mux returns data in the same cycle.

## Interface
- FIFO_DEPTH, 16: TX FIFO entries; power of two, ≥2.
- DEFAULT_DIV, 16'd433: reset value of DIVISOR; bit period = DIV+1 clocks.
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_sel  in  1  access targets this block (top-level MMIO window decode); when 0, i_addr/i_data/i_wren/i_mask are ignored (may be X).
- i_addr  in  30  word offset within the MMIO window.
- i_data  in  32  write data.
- i_wren  in  1  write strobe, sampled at rising edge when i_sel=1.
- i_mask  in  4  byte enables for writes; bit n enables i_data[8n+7:8n].
- o_data  out  32  read data, combinational.
- o_tx  out  1  serial line, idle high, registered.

## Operation
- Register map (word offsets; all others read 0, writes ignored):
  - 0 TXDATA: write with i_mask[0]=1 pushes i_data[7:0]. Reads 0.
  - 1 STATUS (read): [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [15:8] FIFO count, other bits 0. Write with i_mask[0]=1 and i_data[3]=1 clears overflow (W1C); other bits ignored.
  - 2 DIVISOR: [15:0] R/W; i_mask[0] writes [7:0], i_mask[1] writes [15:8]. Reads [31:16]=0.
- o_data = 0 when i_sel=0.
- Push when FIFO count == FIFO_DEPTH: byte dropped, overflow set; full is evaluated on pre-edge count, so a same-cycle pop does not rescue the push.
- Overflow set and W1C clear in the same cycle: set wins.
- FSM IDLE → START → DATA → STOP → IDLE.
  - IDLE: o_tx=1. If FIFO non-empty: pop head into shift register, latch DIVISOR into bit-period reload, go START.
  - START: o_tx=0 for DIV+1 clocks.
  - DATA: 8 bits LSB first, each DIV+1 clocks; 3-bit bit counter.
  - STOP: o_tx=1 for DIV+1 clocks, then IDLE.
- DIVISOR writes mid-frame do not affect the current frame; used from next frame start. DIV=0 is legal (1 clock/bit).
- Bit-period counter 16 bits, loads DIV, counts down to 0; advance on 0.
- FIFO pointers log2(FIFO_DEPTH) bits, wrap modulo depth; count log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert): o_tx=1, FSM IDLE, FIFO empty (count 0, pointers 0), overflow 0, DIVISOR=DEFAULT_DIV, counters 0. Reset mid-frame aborts the frame immediately and flushes the FIFO.
- Write at edge E0 into empty FIFO with FSM IDLE: STATUS.empty=0 after E0; pop at E1; o_tx falls after E1; busy=1 after E1.
- Frame = 10×(DIV+1) clocks from o_tx fall to end of stop bit; next start bit begins the cycle after STOP ends plus one IDLE cycle (pop cycle), i.e. inter-frame gap of exactly 1 clock of idle-high beyond the stop bit when FIFO non-empty.
- STATUS reflects register state as of the most recent edge (no read side effects).

## Test plan
- Reset: assert i_rst_n=0 → o_tx=1, STATUS read = 0x0000_0002, DIVISOR read = 433.
- DIV=3, write 0xA5 to TXDATA → o_tx low 1 cycle after write edge; line sequence 0,1,0,1,0,0,1,0,1,1 each held 4 clocks; busy=0 after 41 clocks.
- DIV=0, write 17 bytes back-to-back with FIFO_DEPTH=16 while transmitter stalls on first frame → exactly one byte dropped only if count was 16 at push; overflow=1; W1C write 0x8 to STATUS → overflow=0; all accepted bytes emitted in order.
- Byte-mask: write 0x1234_5678 with mask 4'b0010 to DIVISOR (reset 433=0x01B1) → reads 0x0000_56B1; write TXDATA with mask 4'b1110 → no push.
- DIVISOR write mid-frame (DIV 3→7) → current frame keeps 4-clock bits, next frame uses 8-clock bits.
- Assert i_rst_n mid-data-bit with 3 bytes queued → o_tx=1 immediately, STATUS=0x2 after release, no further frames.
